// File: rtl/mining_pkg.sv
// Shared definitions for the mining datapath: row/lane geometry,
// controller states and the lane mask helper.
package mining_pkg;

  localparam int ROW_W  = 512;
  localparam int LANE_W = 32;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  // addr_width names the MSB of the lane, so the lane starts 31 bits below it
  function automatic logic [ROW_W-1:0] lane_mask(input logic [8:0] addr_width);
    logic [ROW_W-1:0] lane;
    lane = {{(ROW_W-LANE_W){1'b0}}, {LANE_W{1'b1}}};
    return lane << (addr_width - 9'd31);
  endfunction

endpackage

// File: rtl/chunk_bram_responder_lane_merge.sv
// Merges a 32-bit lane into a 512-bit row at the bit position named by
// addr_width; all bits outside the lane pass through untouched.
module lane_merge
  import mining_pkg::*;
(
  input  logic [ROW_W-1:0]  old_row,
  input  logic [LANE_W-1:0] data_in,
  input  logic [8:0]        addr_width,
  output logic [ROW_W-1:0]  merged_row
);

  logic [ROW_W-1:0] mask;
  logic [ROW_W-1:0] shifted;

  always_comb begin
    mask       = lane_mask(addr_width);
    shifted    = {{(ROW_W-LANE_W){1'b0}}, data_in} << (addr_width - 9'd31);
    merged_row = (old_row & ~mask) | (shifted & mask);
  end

endmodule

// File: rtl/chunk_bram_responder.sv
// Chunk store responder: self-clears after reset, then serves lane writes
// and full-row reads on the controller's active-low strobe protocol.
module chunk_bram_responder
  import mining_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [8:0]        addr_width,
  input  logic [LANE_W-1:0] data_in,
  output logic [ROW_W-1:0]  data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  localparam int CNT_W = $clog2(DEPTH);

  logic [0:0]       state;
  logic [CNT_W-1:0] clr_cnt;
  logic [ROW_W-1:0] mem [DEPTH];

  logic             rd_req, wr_req, addr_ok, width_ok;
  logic             rd_ok, wr_ok, reject;
  logic [CNT_W-1:0] row_idx;
  logic [ROW_W-1:0] merged_row;
  logic             mem_we;
  logic [CNT_W-1:0] mem_waddr;
  logic [ROW_W-1:0] mem_wdata;

  assign busy = (state == CLEAR);

  always_comb begin
    rd_req   = !cs_n && !rd_n && (state == READY);
    wr_req   = !cs_n && !wr_n && (state == READY);
    addr_ok  = addr < ADDR_W'(DEPTH);
    width_ok = (addr_width >= 9'd31) && (int'(addr_width) <= ROW_W - 1);
    row_idx  = addr[CNT_W-1:0];
    rd_ok    = rd_req && addr_ok;
    wr_ok    = wr_req && addr_ok && width_ok;
    // a bad lane position only drops the write half of a combined access
    reject   = (rd_req || wr_req) && (!addr_ok || (wr_req && !width_ok));
  end

  lane_merge u_lane_merge (
    .old_row    (mem[row_idx]),
    .data_in    (data_in),
    .addr_width (addr_width),
    .merged_row (merged_row)
  );

  // Clearing and lane writes share one write port
  always_comb begin
    mem_we    = reset && (busy || wr_ok);
    mem_waddr = busy ? clr_cnt : row_idx;
    mem_wdata = busy ? '0 : merged_row;
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read data comes from the pre-write row, giving read-before-write
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      addr_err <= reject;
      if (rd_ok) data_out <= mem[row_idx];
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == CNT_W'(DEPTH - 1)) state <= READY;
      end
    end
  end

endmodule

// File: tb/tb_chunk_bram_responder.sv
// Scoreboard bench: the driver predicts every cycle's outputs from a row
// array model, a separate monitor pops and compares them after each edge.
module tb_chunk_bram_responder;

  logic         clock;
  logic         reset;
  logic         cs_n, wr_n, rd_n;
  logic [15:0]  addr;
  logic [8:0]   addr_width;
  logic [31:0]  data_in;
  logic [511:0] data_out;
  logic         rd_valid, busy, addr_err;

  chunk_bram_responder dut (
    .clock      (clock),
    .reset      (reset),
    .cs_n       (cs_n),
    .wr_n       (wr_n),
    .rd_n       (rd_n),
    .addr       (addr),
    .addr_width (addr_width),
    .data_in    (data_in),
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .addr_err   (addr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int           due;
    logic         busy;
    logic         valid;
    logic         err;
    logic [511:0] data;
  } exp_t;

  exp_t         exp_q[$];
  logic [511:0] rows [16];
  logic [511:0] held;
  int           clr_left = 16;
  int           drv_cyc = 0;
  int           mon_cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;

  task automatic checkOutput(input string name, input logic [511:0] got, input logic [511:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %h want %h", name, mon_cyc, got, want);
    end
  endtask

  // Drive one cycle of inputs and predict the outputs after the next edge
  task automatic applyStimulus(input bit rst_n, input bit cs, input bit wr, input bit rd,
                               input int a, input int aw, input logic [31:0] d);
    exp_t e;
    bit   rq, wq, a_ok, w_ok;
    reset = rst_n; cs_n = cs; wr_n = wr; rd_n = rd;
    addr = a[15:0]; addr_width = aw[8:0]; data_in = d;
    e.due = drv_cyc + 1; e.busy = 1'b0; e.valid = 1'b0; e.err = 1'b0;
    if (!rst_n) begin
      clr_left = 16;
      held = '0;
      for (int r = 0; r < 16; r++) rows[r] = '0;
      e.busy = 1'b1;
    end else if (clr_left > 0) begin
      clr_left--;
      e.busy = (clr_left > 0);
    end else begin
      rq   = !cs && !rd;
      wq   = !cs && !wr;
      a_ok = (a < 16);
      w_ok = (aw >= 31) && (aw <= 511);
      e.err = (rq || wq) && (!a_ok || (wq && !w_ok));
      if (rq && a_ok) begin
        e.valid = 1'b1;
        held = rows[a];
      end
      if (wq && a_ok && w_ok)
        for (int i = 0; i < 32; i++) rows[a][aw - 31 + i] = d[i];
    end
    e.data = held;
    exp_q.push_back(e);
    @(posedge clock);
    drv_cyc++;
    @(negedge clock);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 1, 1, 1, 0, 31, 32'h0);
  endtask

  task automatic doWrite(input int a, input int aw, input logic [31:0] d);
    applyStimulus(1, 0, 0, 1, a, aw, d);
  endtask

  task automatic doRead(input int a);
    applyStimulus(1, 0, 1, 0, a, 31, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      mon_cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("sync", 512'(mon_cyc), 512'(e.due));
        checkOutput("busy", 512'(busy), 512'(e.busy));
        checkOutput("rd_valid", 512'(rd_valid), 512'(e.valid));
        checkOutput("addr_err", 512'(addr_err), 512'(e.err));
        checkOutput("data_out", data_out, e.data);
      end
    end
  end

  initial begin : driver
    bit c, w, r, rs;
    held = '0;
    $display("[TB] reset and self-clear");
    applyStimulus(0, 1, 1, 1, 0, 31, 32'h0);
    applyStimulus(0, 1, 1, 1, 0, 31, 32'h0);
    idleCycles(18);
    for (int a = 0; a < 16; a++) doRead(a);
    idleCycles(1);

    $display("[TB] lane writes");
    doWrite(3, 511, 32'hDEADBEEF);
    doRead(3);
    doWrite(3, 31, 32'h00000001);
    doRead(3);
    doWrite(3, 40, 32'hFFFFFFFF);
    doRead(3);
    doWrite(3, 40, 32'hFFFFFFFF);
    doRead(3);

    $display("[TB] read-before-write");
    applyStimulus(1, 0, 0, 0, 5, 63, 32'h12345678);
    doRead(5);

    $display("[TB] rejected accesses");
    doRead(16);
    doWrite(16, 100, 32'hA5A5A5A5);
    doWrite(7, 20, 32'hCAFEF00D);
    applyStimulus(1, 0, 0, 0, 5, 20, 32'h0BADF00D);
    applyStimulus(1, 1, 0, 0, 5, 63, 32'h11111111);
    doRead(7);

    $display("[TB] rejected accesses while busy and reset mid-read");
    for (int a = 0; a < 16; a++) doWrite(a, 31 + 32 * (a % 16), $urandom);
    doRead(2);
    doRead(3);
    applyStimulus(0, 0, 1, 0, 4, 31, 32'h0);
    applyStimulus(1, 0, 1, 0, 16, 31, 32'h0);
    applyStimulus(1, 0, 0, 1, 3, 20, 32'h0);
    idleCycles(15);
    for (int a = 0; a < 16; a++) doRead(a);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      c  = ($urandom_range(0, 4) == 0);
      w  = $urandom_range(0, 1);
      r  = $urandom_range(0, 1);
      rs = ($urandom_range(0, 299) != 0);
      applyStimulus(rs, c, w, r, $urandom_range(0, 17),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(0, 30) : $urandom_range(31, 511),
                    $urandom);
    end
    idleCycles(2);

    repeat (3) @(posedge clock);
    #2;
    checkOutput("queue_drained", 512'(exp_q.size()), 512'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chunk_bram_responder.md
Name: chunk_bram_responder

Overview:
- Memory-side responder for the mining datapath's chunk store.
- Answers the active-low cs_n/wr_n/rd_n strobe protocol that the mining controller drives.
- Stores 512-bit SHA-256 message chunks as rows; writes are 32-bit lane writes placed at a bit position given by addr_width; reads return a full row.
- After reset it self-clears the array before accepting any access.

Parameters:
- DEPTH, 16, number of 512-bit rows.
- ADDR_W, 16, address bus width.
- ROW_W, 512, row width in bits.
- LANE_W, 32, write lane width in bits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- cs_n  in  1  chip select, active-low; no access when high
- wr_n  in  1  write strobe, active-low
- rd_n  in  1  read strobe, active-low
- addr  in  ADDR_W  row address
- addr_width  in  9  MSB bit index of the 32-bit write lane within the row
- data_in  in  LANE_W  write data
- data_out  out  ROW_W  registered read data
- rd_valid  out  1  data_out updated this cycle by a read
- busy  out  1  clearing in progress; all accesses ignored
- addr_err  out  1  one-cycle pulse on a rejected access

Behaviour:
- Clock and reset: reset is sampled on the rising edge of clock, active-low (0 = reset).
- Reset values: data_out=0, rd_valid=0, busy=1, addr_err=0, clear counter=0, state=CLEAR.
- CLEAR state:
  - Writes row[clr_cnt]=0 once per cycle, busy=1.
  - clr_cnt goes 0..DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
  - In the cycle after clr_cnt==DEPTH-1 is written, state=READY and busy=0.
  - All strobes are ignored; addr_err is not raised.
- READY state: an access is valid when cs_n==0 and busy==0.
- Write (cs_n=0, wr_n=0):
  - Field row[addr][addr_width -: 32] <= data_in; all other bits are unchanged.
  - Implemented as mask = {LANE_W{1}} << (addr_width-31), shifted data likewise.
- Read (cs_n=0, rd_n=0):
  - data_out <= row[addr] with 1-cycle latency; rd_valid=1 in the cycle data_out holds the new value.
  - data_out holds its value while no read occurs; rd_valid=0 otherwise.
- Simultaneous read and write to the same addr: read-before-write. data_out returns the old row and the write commits in the same edge.
- Rejection (addr_err=1 for one cycle, access dropped, memory and data_out unchanged):
  - addr >= DEPTH, or
  - write with addr_width < 31 or addr_width > ROW_W-1.
  - If both read and write are requested and the address is valid but addr_width is bad, only the write is dropped; the read proceeds.
- cs_n high: wr_n and rd_n are don't-care; no state change except rd_valid=0.
- Strobes are level-sensitive. A strobe held low repeats the access every cycle; repeated identical writes are idempotent.
- Reset mid-operation (reset low in any state): returns to CLEAR and restarts from row 0. Contents are fully zeroed again; any in-flight read is lost and rd_valid=0.
- Unaligned addr_width (for example 40) is legal and writes bits [40:9].

Decomposition:
- Shared package mining_pkg: ROW_W, LANE_W, the state enum {CLEAR, READY}, and a function lane_mask(addr_width) returning the ROW_W-bit mask.
- One natural sub-module: lane_merge (combinational).
  - Inputs: old row, data_in, addr_width. Output: merged row.
  - Reused later by the nonce-update path.
- The row array is inferred as registers or distributed RAM; clear and write share a single write port through a mux.

Test Plan:
- Reset then idle -> busy=1 for exactly 16 cycles and then 0. A read of rows 0..15 returns all zeros with rd_valid=1 one cycle after each rd_n.
- Write addr=3, addr_width=511, data=0xDEADBEEF; then read addr=3 -> data_out[511:480]=0xDEADBEEF and the remaining bits are 0.
- Write addr=3, addr_width=31, data=0x00000001 after the previous test; read -> both lanes present. Then write with addr_width=40, data=0xFFFFFFFF -> bits [40:9] are set and all other bits are preserved.
- Same cycle rd_n=0 and wr_n=0 on addr=5 (old=0), data=0x12345678 at addr_width=63 -> data_out=0 that cycle. The next read shows 0x12345678 at [63:32].
- Access with addr=16, or a write with addr_width=20 -> addr_err pulses for 1 cycle, no memory change, rd_valid=0. The same rejected accesses issued while busy=1 -> no addr_err.
- Fill rows, then assert reset low for 1 cycle during a read stream -> busy=1 for 16 cycles, rd_valid=0. All rows read back as 0 afterwards.
